// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants: axis arithmetic helpers and standard mode presets.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_active;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
    logic        h_pol;
    logic        v_pol;
  } vga_mode_t;

  function automatic int unsigned axis_total(input int unsigned sync, input int unsigned back,
                                             input int unsigned active, input int unsigned front);
    return sync + back + active + front;
  endfunction

  function automatic int unsigned active_first(input int unsigned sync, input int unsigned back);
    return sync + back;
  endfunction

  function automatic int unsigned active_last(input int unsigned sync, input int unsigned back,
                                              input int unsigned active);
    return sync + back + active - 1;
  endfunction

  localparam vga_mode_t VGA_640X480_60 = '{h_active: 640, h_front: 16, h_sync: 96, h_back: 48,
                                           v_active: 480, v_front: 10, v_sync: 2, v_back: 33,
                                           h_pol: 1'b0, v_pol: 1'b0};

  localparam vga_mode_t VGA_800X600_60 = '{h_active: 800, h_front: 40, h_sync: 128, h_back: 88,
                                           v_active: 600, v_front: 1, v_sync: 4, v_back: 23,
                                           h_pol: 1'b1, v_pol: 1'b1};

  localparam int unsigned H_TOTAL = axis_total(VGA_640X480_60.h_sync, VGA_640X480_60.h_back,
                                               VGA_640X480_60.h_active, VGA_640X480_60.h_front);
  localparam int unsigned V_TOTAL = axis_total(VGA_640X480_60.v_sync, VGA_640X480_60.v_back,
                                               VGA_640X480_60.v_active, VGA_640X480_60.v_front);
  localparam int unsigned H_ACTIVE_FIRST = active_first(VGA_640X480_60.h_sync, VGA_640X480_60.h_back);
  localparam int unsigned H_ACTIVE_LAST  = active_last(VGA_640X480_60.h_sync, VGA_640X480_60.h_back,
                                                       VGA_640X480_60.h_active);
  localparam int unsigned V_ACTIVE_FIRST = active_first(VGA_640X480_60.v_sync, VGA_640X480_60.v_back);
  localparam int unsigned V_ACTIVE_LAST  = active_last(VGA_640X480_60.v_sync, VGA_640X480_60.v_back,
                                                       VGA_640X480_60.v_active);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync/active decode of the next count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned CW     = 12,
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FRONT  = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BACK   = 48,
  parameter bit          POL    = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          last,
  output logic          wrap,
  output logic          sync,
  output logic          active,
  output logic [CW-1:0] rel
);

  localparam int unsigned   TOTAL    = axis_total(SYNC, BACK, ACTIVE, FRONT);
  localparam logic [CW-1:0] LAST_CNT = CW'(TOTAL - 1);
  localparam logic [CW-1:0] A_FIRST  = CW'(active_first(SYNC, BACK));
  localparam logic [CW-1:0] A_SPAN   = CW'(ACTIVE);
  localparam logic [CW-1:0] S_SPAN   = CW'(SYNC);

  logic          adv;
  logic          wrap_next;
  logic          sync_next;
  logic [CW-1:0] count_next;

  always_comb begin
    last       = (count == LAST_CNT);
    adv        = en & step;
    wrap_next  = adv & last;
    count_next = count;
    if (adv) count_next = last ? '0 : count + 1'b1;
    rel        = count_next - A_FIRST;
    // counts below A_FIRST wrap modulo 2**CW to >= A_SPAN, so one compare covers the window
    active     = (rel < A_SPAN);
    sync_next  = (count_next < S_SPAN) ? POL : ~POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
      sync  <= POL;
    end else if (en) begin
      count <= count_next;
      wrap  <= wrap_next;
      sync  <= sync_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator; every output registered and aligned to position_x/y.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CW       = 12,
  parameter int unsigned H_ACTIVE = VGA_640X480_60.h_active,
  parameter int unsigned H_FRONT  = VGA_640X480_60.h_front,
  parameter int unsigned H_SYNC   = VGA_640X480_60.h_sync,
  parameter int unsigned H_BACK   = VGA_640X480_60.h_back,
  parameter int unsigned V_ACTIVE = VGA_640X480_60.v_active,
  parameter int unsigned V_FRONT  = VGA_640X480_60.v_front,
  parameter int unsigned V_SYNC   = VGA_640X480_60.v_sync,
  parameter int unsigned V_BACK   = VGA_640X480_60.v_back,
  parameter bit          H_POL    = VGA_640X480_60.h_pol,
  parameter bit          V_POL    = VGA_640X480_60.v_pol,
  parameter int unsigned FC_W     = 8
) (
  input  logic            vga_CLK,
  input  logic            vga_RSTn,
  input  logic            vga_En,
  output logic            HSync,
  output logic            VSync,
  output logic            vga_Ready,
  output logic [CW-1:0]   position_x,
  output logic [CW-1:0]   position_y,
  output logic [CW-1:0]   pix_x,
  output logic [CW-1:0]   pix_y,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_cnt
);

  logic          h_last, v_last;
  logic          h_active, v_active;
  logic          ready_next;
  logic [CW-1:0] h_rel, v_rel;

  vga_axis_counter #(
    .CW(CW), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(H_POL)
  ) u_h (
    .clk(vga_CLK), .rst_n(vga_RSTn), .en(vga_En), .step(1'b1),
    .count(position_x), .last(h_last), .wrap(line_start), .sync(HSync),
    .active(h_active), .rel(h_rel)
  );

  // vertical axis steps only on the horizontal wrap, so its wrap pulse is the frame strobe
  vga_axis_counter #(
    .CW(CW), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(V_POL)
  ) u_v (
    .clk(vga_CLK), .rst_n(vga_RSTn), .en(vga_En), .step(h_last),
    .count(position_y), .last(v_last), .wrap(frame_start), .sync(VSync),
    .active(v_active), .rel(v_rel)
  );

  assign ready_next = h_active & v_active;

  always_ff @(posedge vga_CLK or negedge vga_RSTn) begin
    if (!vga_RSTn) begin
      vga_Ready <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      frame_cnt <= '0;
    end else if (vga_En) begin
      vga_Ready <= ready_next;
      pix_x     <= ready_next ? h_rel : '0;
      pix_y     <= ready_next ? v_rel : '0;
      if (h_last & v_last) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator; next generation of the team's fixed 640x480 sync block. It adds programmable porch/sync/active sizes, per-axis sync polarity, a pause enable, and active-relative pixel coordinates. It also adds line/frame start strobes and a wrapping frame counter, with all outputs registered and glitch-free. It sits between the pixel clock domain and the pixel/colour generators, driving the VGA connector syncs directly.

Parameters:
CW, 12, width of all counters and coordinate outputs
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
H_POL, 0, HSync active level (0 = active-low)
V_POL, 0, VSync active level (0 = active-low)
FC_W, 8, frame counter width

Ports:
vga_CLK  in  1  pixel clock, all logic on rising edge
vga_RSTn  in  1  asynchronous active-low reset
vga_En  in  1  count enable; low freezes the raster
HSync  out  1  horizontal sync at H_POL level during sync region
VSync  out  1  vertical sync at V_POL level during sync region
vga_Ready  out  1  high when the current pixel is in the visible area
position_x  out  CW  raw horizontal count, 0..H_TOTAL-1
position_y  out  CW  raw vertical count, 0..V_TOTAL-1
pix_x  out  CW  visible column, 0..H_ACTIVE-1; 0 when not vga_Ready
pix_y  out  CW  visible row, 0..V_ACTIVE-1; 0 when not vga_Ready
line_start  out  1  one-cycle pulse when position_x wraps to 0
frame_start  out  1  one-cycle pulse when position_x and position_y both wrap to 0
frame_cnt  out  FC_W  completed frames, modulo 2^FC_W

Behaviour:
- H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (default 800). V_TOTAL is the same sum for the vertical axis (default 525).
- Region order per axis: sync [0, SYNC-1], back porch, active [SYNC+BACK, SYNC+BACK+ACTIVE-1], front porch [.., TOTAL-1].
- Reset (async assert, sync release) sets the following; reset mid-operation forces these values immediately, regardless of vga_En:
  - position_x = position_y = 0
  - pix_x = pix_y = 0, frame_cnt = 0
  - vga_Ready = 0, line_start = frame_start = 0
  - HSync = H_POL, VSync = V_POL, because (0,0) is inside the sync region.
- Each enabled edge advances the raster:
  - position_x increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap, position_y increments, and wraps to 0 from V_TOTAL-1.
- All outputs are registers decoded from the next count, so every output is aligned with the position_x/position_y value of the same cycle. There is zero latency relative to the counters.
- HSync = (x < H_SYNC) ? H_POL : !H_POL. VSync uses the same rule on y, counted in lines; it toggles only at x wrap.
- vga_Ready = x in active range AND y in active range. When vga_Ready is high, pix_x = x-(H_SYNC+H_BACK) and pix_y = y-(V_SYNC+V_BACK).
- line_start = 1 on the cycle the count became x = 0 through a wrap. frame_start additionally requires y = 0.
  - No strobe follows reset release: the first line_start occurs at the first wrap.
- frame_cnt increments in the cycle frame_start asserts; it wraps from 2^FC_W-1 to 0.
- vga_En low holds every output register at its current value, strobes included. A strobe that was high stays high only while frozen and drops on the next enabled edge.
- Width rules: CW must hold H_TOTAL-1 and V_TOTAL-1; compare in CW bits; no truncation warnings permitted.

Decomposition:
- Package vga_timing_pkg holds:
  - the derived constants H_TOTAL and V_TOTAL
  - the active start/end values per axis
  - a localparam struct or set of constants for the 640x480@60 and 800x600@60 presets.
- One sub-module, vga_axis_counter: a parametrised wrap counter. Inputs: en, wrap-enable chain. Outputs: count, wrap pulse, sync, active. Instantiate it twice (horizontal, and vertical chained on the horizontal wrap).

Test Plan:
- Release reset with En=1, run 800 edges -> position_x=0, position_y=1, line_start high exactly that cycle, frame_start low.
- Defaults with H_POL=0: HSync=0 for x 0..95 and 1 for x 96..799. VSync=0 only for y 0..1.
- Visible window: vga_Ready first high at (144,35) with pix=(0,0); last high at (783,514) with pix=(639,479); low at x=784 and at y=515.
- Run 420000 enabled edges -> position=(0,0), frame_start=1 for one cycle, frame_cnt=1. With FC_W=2, after 4 frames frame_cnt wraps to 0.
- Drop En at x=200 for 10 cycles -> all outputs constant; after En returns, the next edge gives x=201. Asserting vga_RSTn low at (500,300) -> outputs reach reset values without a clock edge.
- Override to H=4/1/2/1, V=3/1/1/1, H_POL=V_POL=1 -> H_TOTAL=8 and V_TOTAL=6; HSync high only at x=0..1; frame_start every 48 cycles.
